// File: rtl/dmem_lsu_if.sv
// Shared sizing constants and the LSU bus interface: core request/response
// channel plus the single-port data memory port.
package params_pkg;
  parameter int ADDR_WIDTH = 8;
  parameter int DATA_WIDTH = 32;
endpackage

interface dmem_lsu_if #(
  parameter int ADDR_WIDTH = params_pkg::ADDR_WIDTH
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [1:0]            req_size_i;
  logic                  req_unsigned_i;
  logic [ADDR_WIDTH+1:0] req_addr_i;
  logic [31:0]           req_wdata_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [31:0]           rsp_rdata_o;
  logic                  rsp_err_o;
  logic                  mem_wr_en_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [31:0]           mem_wr_data_o;
  logic [31:0]           mem_rd_data_i;

  // LSU side
  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    input  rsp_ready_i, mem_rd_data_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output mem_wr_en_o, mem_addr_o, mem_wr_data_o
  );

  // Core + memory side
  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    output rsp_ready_i, mem_rd_data_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  mem_wr_en_o, mem_addr_o, mem_wr_data_o
  );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit: one transaction in flight, sub-word stores done as
// read-modify-write against a word-only write-enable memory.
module dmem_lsu #(
  parameter int ADDR_WIDTH = params_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = params_pkg::DATA_WIDTH
) (
  input logic       clk_i,
  input logic       rst_i,
  dmem_lsu_if.slave bus
);
  if (DATA_WIDTH != 32) begin : g_width_check
    $error("dmem_lsu: DATA_WIDTH must be 32");
  end

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [1:0]            lane_q, lane_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wr_data_q, wr_data_d;
  logic                  illegal;

  // Shift the addressed lane down to bit 0 and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] lane, input logic uns);
    logic [31:0] sh;
    sh = w >> {lane, 3'b000};
    case (sz)
      2'b00:   return {{24{~uns & sh[7]}}, sh[7:0]};
      2'b01:   return {{16{~uns & sh[15]}}, sh[15:0]};
      default: return w;
    endcase
  endfunction

  // Replace only the addressed lane(s) of the read word with store data.
  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [1:0] lane);
    logic [31:0] mask;
    mask = (sz == 2'b00) ? (32'h0000_00FF << {lane, 3'b000}) : (32'h0000_FFFF << {lane, 3'b000});
    return (w & ~mask) | ((wd << {lane, 3'b000}) & mask);
  endfunction

  // Reserved size or misaligned half/word
  always_comb begin
    illegal = (bus.req_size_i == 2'b11) ||
              (bus.req_size_i == 2'b01 && bus.req_addr_i[0]) ||
              (bus.req_size_i == 2'b10 && bus.req_addr_i[1:0] != 2'b00);
  end

  // Next-state, latched request fields and registered outputs
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    size_d    = size_q;
    uns_d     = uns_q;
    lane_d    = lane_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid_i) begin
          we_d    = bus.req_we_i;
          size_d  = bus.req_size_i;
          uns_d   = bus.req_unsigned_i;
          lane_d  = bus.req_addr_i[1:0];
          wdata_d = bus.req_wdata_i;
          rdata_d = '0;
          if (illegal) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            err_d  = 1'b0;
            addr_d = bus.req_addr_i[ADDR_WIDTH+1:2];
            if (bus.req_we_i && bus.req_size_i == 2'b10) begin
              wr_data_d = bus.req_wdata_i;
              state_d   = S_WRITE;
            end else begin
              state_d = S_READ;
            end
          end
        end
      end
      S_READ: begin
        if (we_q) begin
          wr_data_d = store_merge(bus.mem_rd_data_i, wdata_q, size_q, lane_q);
          state_d   = S_WRITE;
        end else begin
          rdata_d = load_extract(bus.mem_rd_data_i, size_q, lane_q, uns_q);
          state_d = S_RESP;
        end
      end
      S_WRITE: state_d = S_RESP;
      S_RESP: begin
        if (bus.rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      lane_q    <= 2'b00;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      lane_q    <= lane_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.req_ready_o   = (state_q == S_IDLE);
  assign bus.rsp_valid_o   = (state_q == S_RESP);
  assign bus.rsp_rdata_o   = rdata_q;
  assign bus.rsp_err_o     = err_q;
  assign bus.mem_wr_en_o   = (state_q == S_WRITE);
  assign bus.mem_addr_o    = addr_q;
  assign bus.mem_wr_data_o = wr_data_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a transaction-level reference model.
module tb_dmem_lsu;
  localparam int AW = params_pkg::ADDR_WIDTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_lsu_if #(.ADDR_WIDTH(AW)) bus();
  dmem_lsu #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  logic [31:0] tb_mem  [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];

  assign bus.mem_rd_data_i = tb_mem[bus.mem_addr_o];
  always @(posedge clk) if (bus.mem_wr_en_o) tb_mem[bus.mem_addr_o] <= bus.mem_wr_data_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic          cmp_en = 1'b0;
  logic          exp_ready = 1'b1, exp_valid = 1'b0, exp_wr_en = 1'b0, exp_err = 1'b0;
  logic [31:0]   exp_rdata = '0, exp_mwdata = '0;
  logic [AW-1:0] exp_maddr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model's expected timeline
  always @(negedge clk) begin
    if (cmp_en) begin
      check("req_ready", {31'd0, bus.req_ready_o}, {31'd0, exp_ready});
      check("rsp_valid", {31'd0, bus.rsp_valid_o}, {31'd0, exp_valid});
      check("mem_wr_en", {31'd0, bus.mem_wr_en_o}, {31'd0, exp_wr_en});
      if (exp_valid) begin
        check("rsp_rdata", bus.rsp_rdata_o, exp_rdata);
        check("rsp_err", {31'd0, bus.rsp_err_o}, {31'd0, exp_err});
      end
      if (exp_wr_en) begin
        check("mem_addr", {{(32-AW){1'b0}}, bus.mem_addr_o}, {{(32-AW){1'b0}}, exp_maddr});
        check("mem_wr_data", bus.mem_wr_data_o, exp_mwdata);
      end
    end
  end

  task automatic do_txn(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [AW+1:0] addr, input logic [31:0] wd, input int hold,
                        output logic [31:0] got_rdata, output logic got_err,
                        output int got_lat, output int got_wr);
    logic [AW-1:0] idx;
    int            b, lat;
    logic          err, done;
    logic [31:0]   word, v, mask, nw;
    idx  = addr[AW+1:2];
    b    = int'(addr[1:0]);
    err  = (sz == 2'd3) || (sz == 2'd1 && b % 2 == 1) || (sz == 2'd2 && b != 0);
    word = ref_mem[idx];
    v    = 32'd0;
    if (sz == 2'd0) begin
      v = (word >> (8*b)) & 32'hFF;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (word >> (8*b)) & 32'hFFFF;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = word;
    end
    mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    nw   = (word & ~(mask << (8*b))) | ((wd & mask) << (8*b));
    lat  = err ? 1 : (!we ? 2 : (sz == 2'd2 ? 2 : 3));

    @(negedge clk);
    bus.req_valid_i    = 1'b1;
    bus.req_we_i       = we;
    bus.req_size_i     = sz;
    bus.req_unsigned_i = uns;
    bus.req_addr_i     = addr;
    bus.req_wdata_i    = wd;
    bus.rsp_ready_i    = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    got_wr = 0; got_lat = 0; got_rdata = '0; got_err = 1'b0; done = 1'b0;
    for (int k = 1; k < 60 && !done; k++) begin
      exp_ready  = 1'b0;
      exp_valid  = (k >= lat);
      exp_wr_en  = we && !err && (k == lat - 1);
      exp_maddr  = idx;
      exp_mwdata = nw;
      exp_rdata  = (we || err) ? 32'd0 : v;
      exp_err    = err;
      if (k >= lat) bus.rsp_ready_i = (k - lat >= hold);
      @(negedge clk);
      if (bus.rsp_valid_o && got_lat == 0) got_lat = k;
      if (bus.mem_wr_en_o) got_wr++;
      got_rdata = bus.rsp_rdata_o;
      got_err   = bus.rsp_err_o;
      @(posedge clk);
      #1;
      if (k >= lat && bus.rsp_ready_i) done = 1'b1;
    end
    if (!done) check("txn_timeout", 32'd0, 32'd1);
    exp_ready = 1'b1; exp_valid = 1'b0; exp_wr_en = 1'b0;
    bus.rsp_ready_i = 1'b0;
    if (we && !err) ref_mem[idx] = nw;
  endtask

  logic [31:0] r;
  logic        e;
  int          lt, nwr;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1<<AW); i++) begin
      tb_mem[i]  = 32'(i);
      ref_mem[i] = 32'(i);
    end
    bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_size_i = 2'b00;
    bus.req_unsigned_i = 1'b0; bus.req_addr_i = '0; bus.req_wdata_i = '0;
    bus.rsp_ready_i = 1'b0;
    rst = 1'b1;
    #2;
    check("rst req_ready", {31'd0, bus.req_ready_o}, 32'd1);
    check("rst rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
    check("rst mem_wr_en", {31'd0, bus.mem_wr_en_o}, 32'd0);
    check("rst rsp_rdata", bus.rsp_rdata_o, 32'd0);
    check("rst mem_addr", {{(32-AW){1'b0}}, bus.mem_addr_o}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;

    do_txn(1'b0, 2'd2, 1'b0, 10'h014, 32'd0, 0, r, e, lt, nwr);
    check("lw14 rdata", r, 32'h0000_0005);
    check("lw14 lat", 32'(lt), 32'd2);
    check("lw14 wr", 32'(nwr), 32'd0);

    do_txn(1'b1, 2'd2, 1'b0, 10'h020, 32'hDEAD_BEEF, 0, r, e, lt, nwr);
    check("sw20 wr pulses", 32'(nwr), 32'd1);
    check("sw20 lat", 32'(lt), 32'd2);
    check("sw20 mem", tb_mem[8], 32'hDEAD_BEEF);
    do_txn(1'b0, 2'd2, 1'b0, 10'h020, 32'd0, 0, r, e, lt, nwr);
    check("lw20 rdata", r, 32'hDEAD_BEEF);

    do_txn(1'b1, 2'd0, 1'b0, 10'h021, 32'h0000_00AA, 0, r, e, lt, nwr);
    check("sb21 lat", 32'(lt), 32'd3);
    check("sb21 mem", tb_mem[8], 32'hDEAD_AAEF);
    do_txn(1'b0, 2'd0, 1'b0, 10'h021, 32'd0, 0, r, e, lt, nwr);
    check("lb21", r, 32'hFFFF_FFAA);
    do_txn(1'b0, 2'd0, 1'b1, 10'h021, 32'd0, 0, r, e, lt, nwr);
    check("lbu21", r, 32'h0000_00AA);
    do_txn(1'b0, 2'd1, 1'b0, 10'h022, 32'd0, 0, r, e, lt, nwr);
    check("lh22", r, 32'hFFFF_DEAD);
    do_txn(1'b0, 2'd1, 1'b1, 10'h022, 32'd0, 0, r, e, lt, nwr);
    check("lhu22", r, 32'h0000_DEAD);

    do_txn(1'b1, 2'd1, 1'b0, 10'h023, 32'h0000_1234, 0, r, e, lt, nwr);
    check("sh23 err", {31'd0, e}, 32'd1);
    check("sh23 lat", 32'(lt), 32'd1);
    check("sh23 wr", 32'(nwr), 32'd0);
    do_txn(1'b0, 2'd3, 1'b0, 10'h000, 32'd0, 0, r, e, lt, nwr);
    check("sz3 err", {31'd0, e}, 32'd1);
    check("sz3 rdata", r, 32'd0);
    do_txn(1'b0, 2'd2, 1'b0, 10'h022, 32'd0, 0, r, e, lt, nwr);
    check("lw22 err", {31'd0, e}, 32'd1);
    check("lw22 lat", 32'(lt), 32'd1);

    do_txn(1'b1, 2'd1, 1'b0, 10'h02A, 32'hFFFF_1234, 0, r, e, lt, nwr);
    check("sh2A mem", tb_mem[10], 32'h1234_000A);
    do_txn(1'b0, 2'd1, 1'b1, 10'h02A, 32'd0, 0, r, e, lt, nwr);
    check("lhu2A", r, 32'h0000_1234);
    do_txn(1'b0, 2'd0, 1'b0, 10'h028, 32'd0, 0, r, e, lt, nwr);
    check("lb28", r, 32'h0000_000A);

    do_txn(1'b0, 2'd2, 1'b0, 10'h014, 32'd0, 3, r, e, lt, nwr);
    check("hold rdata", r, 32'h0000_0005);
    do_txn(1'b0, 2'd2, 1'b0, 10'h020, 32'd0, 0, r, e, lt, nwr);
    check("after hold rdata", r, 32'hDEAD_AAEF);

    // Asynchronous reset while a word store is in its write cycle
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_size_i = 2'd2;
    bus.req_unsigned_i = 1'b0; bus.req_addr_i = 10'h030; bus.req_wdata_i = 32'h1234_5678;
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    cmp_en = 1'b0;
    check("pre-rst wr_en", {31'd0, bus.mem_wr_en_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async wr_en", {31'd0, bus.mem_wr_en_o}, 32'd0);
    check("async req_ready", {31'd0, bus.req_ready_o}, 32'd1);
    check("async rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
    check("async mem_addr", {{(32-AW){1'b0}}, bus.mem_addr_o}, 32'd0);
    check("async mem_wr_data", bus.mem_wr_data_o, 32'd0);
    check("async rsp_err", {31'd0, bus.rsp_err_o}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("word12 intact", tb_mem[12], 32'h0000_000C);
    cmp_en = 1'b1;
    do_txn(1'b0, 2'd2, 1'b0, 10'h030, 32'd0, 0, r, e, lt, nwr);
    check("lw30", r, 32'h0000_000C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store initiator that sits between the multi-cycle core datapath and the word-addressed data memory.
- Accepts byte, half-word and word load/store requests from the core over a valid/ready handshake.
- Drives the single-port data memory interface. Sub-word stores are done as read-modify-write because the memory has only a whole-word write enable.
- Returns extended load data, or an error flag for illegal accesses, over a valid/ready response channel.

Parameters:
- ADDR_WIDTH, default params_pkg::ADDR_WIDTH: word-index width on the memory side.
- DATA_WIDTH, default params_pkg::DATA_WIDTH: word width. Must be 32; elaboration error otherwise.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  core request valid.
- req_ready_o  out  1  LSU can accept a request.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned_i  in  1  zero-extend loads when 1, sign-extend when 0.
- req_addr_i  in  ADDR_WIDTH+2  byte address.
- req_wdata_i  in  32  store data, right-aligned.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  core accepts response.
- rsp_rdata_o  out  32  extended load data; 0 for stores and errors.
- rsp_err_o  out  1  misaligned or reserved-size access.
- mem_wr_en_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_WIDTH  memory word index (req_addr_i[ADDR_WIDTH+1:2]).
- mem_wr_data_o  out  32  memory write data.
- mem_rd_data_i  in  32  memory read data, combinational from mem_addr_o.

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - req_ready_o=1; rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0.
  - mem_wr_en_o=0, mem_addr_o=0, mem_wr_data_o=0.
  - Memory contents are not touched.
- FSM states: IDLE, READ, WRITE, RESP. Only one transaction is in flight; req_ready_o=1 only in IDLE.
- IDLE: accept on req_valid_i && req_ready_o and latch all request fields. Next state:
  - size=11, half with addr[0]=1, or word with addr[1:0]!=0 → RESP with err=1. No memory access.
  - Load, or sub-word store → READ.
  - Word store → WRITE, with mem_wr_data_o = wdata.
- READ (1 cycle): mem_addr_o holds the latched index; mem_rd_data_i is captured at the cycle end.
  - Load → RESP with extracted data.
  - Sub-word store → WRITE with merged word.
- Lane rules (little-endian):
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Load extraction shifts the lane down, then sign- or zero-extends per req_unsigned_i.
  - Store merge replaces only the target lane(s) with the low bits of wdata; all other bytes are kept from the read word.
- WRITE (1 cycle): mem_wr_en_o=1, with mem_addr_o and mem_wr_data_o stable. Next state is RESP. mem_wr_en_o is high in no other state.
- RESP: rsp_valid_o=1, with rdata and err held stable until rsp_ready_i. On handshake, go to IDLE and drop rsp_valid_o the next cycle.
- Latency from accept edge to rsp_valid_o high:
  - Error: 1 cycle.
  - Word store: 2 cycles.
  - Load: 2 cycles.
  - Sub-word store: 3 cycles.
- mem_addr_o and mem_wr_data_o keep their last values outside active states.
- A new request cannot be accepted in the same cycle as a response handshake.
- Reset asserted in WRITE before the clock edge: the write is lost, mem_wr_en_o drops immediately, and no response is produced.

Test Plan:
- Memory initialised word i = i; load word, addr 0x14 → rsp_rdata_o=0x00000005, err=0, rsp_valid_o 2 cycles after accept, mem_wr_en_o never high.
- Store word 0xDEADBEEF at 0x20, then load 0x20 → mem_wr_en_o high exactly 1 cycle with mem_addr_o=8; load returns 0xDEADBEEF.
- After the above, sub-word accesses:
  - Store byte 0xAA at 0x21 → memory word 8 = 0xDEADAAEF; response 3 cycles after accept.
  - Signed byte load 0x21 → 0xFFFFFFAA; unsigned byte load 0x21 → 0x000000AA.
  - Signed half load 0x22 → 0xFFFFDEAD; unsigned half load 0x22 → 0x0000DEAD.
- Half store at 0x23, size=11 load at 0x00, and word load at 0x22 → each gives err=1, rdata=0, response 1 cycle after accept, no mem_wr_en_o pulse.
- Load with rsp_ready_i held low 3 cycles → rsp_valid_o and rsp_rdata_o stable, req_ready_o=0; new request accepted only after handshake and return to IDLE.
- Assert rst_i asynchronously mid-cycle while in WRITE for store 0x12345678 to 0x30 → all outputs reset without waiting for a clock edge; word 12 still reads 0x0000000C.
